out_port_fifo: RTL
==================

// Module: out_port_fifo
//
// PURPOSE
// - Output Port for the Mini SRC CPU; the transmit-side counterpart of the Input Port.
// - Captures 32-bit words driven on the CPU bus when the control unit asserts OutPortin.
// - Buffers them in a small FIFO and presents them to an external device with a
//   valid/ready handshake, so a slow device does not lose back-to-back OUT instructions.
// - Full/empty/count status lets the control unit stall an OUT instruction when needed.
//
// PARAMETERS
// - DEPTH  default 4  FIFO entries; power of two, >= 2.
// - AW     default 2  pointer width, = $clog2(DEPTH).
//
// PORTS
// - clock        in   1     system clock; all state updates on rising edge.
// - clear        in   1     synchronous, active-high reset.
// - BusMuxOut    in   32    CPU bus value to be written.
// - OutPortin    in   1     push request: write BusMuxOut this cycle.
// - OutPortData  out  32    head-of-FIFO word to the external device.
// - out_valid    out  1     OutPortData holds a valid word (= !empty).
// - out_ready    in   1     external device accepts the word this cycle.
// - out_full     out  1     FIFO holds DEPTH words.
// - out_empty    out  1     FIFO holds 0 words.
// - out_count    out  AW+1  words currently stored, 0..DEPTH.
// - out_ovf      out  1     sticky overflow flag (see CONFIGURATION).
//
// BEHAVIOUR
// - Reset (clear=1 at posedge): pointers = 0, count = 0, out_ovf = 0.
//   Resulting outputs: out_empty = 1, out_full = 0, out_valid = 0, OutPortData = 0.
//   Memory contents need not be cleared.
//   clear overrides any simultaneous push or pop; an in-flight handshake is discarded.
// - Push accepted when OutPortin = 1 AND (!out_full OR pop this cycle).
//   Accepted push: word written at wr_ptr, wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
// - Pop occurs when out_valid = 1 AND out_ready = 1.
//   Pop: rd_ptr increments modulo DEPTH.
//   out_ready while out_valid = 0 has no effect.
// - Count update: +1 on push only, -1 on pop only, unchanged when both or neither.
// - Simultaneous push + pop when full: both occur, count stays DEPTH, no overflow.
// - Simultaneous push + pop when empty: impossible; pop requires out_valid.
//   The push is taken, count -> 1.
// - Empty push latency: no bypass. A word pushed at edge N is visible on
//   OutPortData with out_valid = 1 after edge N (one-cycle latency).
// - Push refused (full and no pop): word dropped, FIFO state unchanged, overflow event raised.
// - Output stability: OutPortData = mem[rd_ptr] when !out_empty, else 32'h0.
//   The value is held stable while out_valid = 1 and out_ready = 0.
// - Status outputs (out_full, out_empty, out_count) derive only from registered state.
//   No combinational path from OutPortin or out_ready to any status output.
// - Data is passed unmodified: no width or sign transformation.
//
// CONFIGURATION
// - Macro: OUTPORT_OVF_EN.
// - Defined: out_ovf is set to 1 on the edge where a push is refused.
//   It stays 1 until clear.
// - Undefined: out_ovf is tied to 0. Refused pushes are still silently dropped.
//   All other behaviour is identical.
//
// TESTING
// - Reset: drive clear = 1 for 1 cycle mid-stream with count = 3 -> next cycle
//   count = 0, out_empty = 1, out_valid = 0, OutPortData = 0.
// - Single word: push 32'hDEADBEEF with out_ready = 0 -> next cycle out_valid = 1,
//   data = DEADBEEF, held 5 cycles. Then out_ready = 1 -> popped, out_empty = 1.
// - Fill/overflow: push 1, 2, 3, 4, 5 back-to-back with out_ready = 0 ->
//   out_full = 1 after the 4th push, word 5 dropped.
//   With OUTPORT_OVF_EN defined, out_ovf = 1. Drain then yields 1, 2, 3, 4 in order.
// - Full push+pop: with FIFO full of 1..4, push 9 with out_ready = 1 in the same cycle ->
//   count stays 4, out_ovf stays 0. Drain yields 2, 3, 4, 9.
// - Wrap-around: stream 10 words with out_ready toggling 1/0 each cycle ->
//   all 10 received in order, pointers wrap at least twice, never overflow.
// - Empty push + ready: out_ready = 1 held while pushing 32'h00000007 into an empty FIFO ->
//   out_valid rises next cycle and the word pops that cycle, count returns to 0.

Source files
------------

// File: rtl/out_port_fifo.sv
// out_port_fifo: Mini SRC CPU output port, buffering OUT words in a small FIFO
// drained by an external device through a valid/ready handshake.
//
// Ports:
//   clock        in   1     system clock, rising edge
//   clear        in   1     synchronous active-high reset
//   BusMuxOut    in   32    CPU bus word to write
//   OutPortin    in   1     push request
//   OutPortData  out  32    head-of-FIFO word (0 when empty)
//   out_valid    out  1     OutPortData holds a valid word
//   out_ready    in   1     external device accepts the head word
//   out_full     out  1     FIFO holds DEPTH words
//   out_empty    out  1     FIFO holds no words
//   out_count    out  AW+1  words stored, 0..DEPTH
//   out_ovf      out  1     sticky overflow flag
//
// Build option: define OUTPORT_OVF_EN to make out_ovf latch refused pushes;
// otherwise out_ovf is tied low and refused pushes are silently dropped.
module out_port_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clock,
    input  logic          clear,
    input  logic [31:0]   BusMuxOut,
    input  logic          OutPortin,
    output logic [31:0]   OutPortData,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_full,
    output logic          out_empty,
    output logic [AW:0]   out_count,
    output logic          out_ovf
);
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign out_empty   = out_count == '0;
    assign out_full    = out_count == (AW+1)'(DEPTH);
    assign out_valid   = !out_empty;
    assign OutPortData = out_empty ? 32'h0 : mem[rd_ptr];
    assign pop         = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign push        = OutPortin && (!out_full || pop);

    always_ff @(posedge clock)
        if (push)
            mem[wr_ptr] <= BusMuxOut;

    // DEPTH is a power of two, so pointer wrap is plain binary overflow.
    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                out_count <= out_count + (AW+1)'(1);
            else if (pop && !push)
                out_count <= out_count - (AW+1)'(1);
        end
    end

`ifdef OUTPORT_OVF_EN
    logic ovf_q;

    always_ff @(posedge clock) begin
        if (clear)
            ovf_q <= 1'b0;
        else if (OutPortin && !push)
            ovf_q <= 1'b1;
    end

    assign out_ovf = ovf_q;
`else
    assign out_ovf = 1'b0;
`endif
endmodule
